xor_fault_monitor: RTL and testbench

Sequential stimulus/checker stage wrapped around the 6-input XOR laser target. It drives the target's 6-bit input `a` through all 64 patterns and samples the target's output `q` after a settle window. It compares the sample against expected parity and reports every mismatch (laser-induced fault) over a valid/ready interface, with saturating fault and sweep counters. It sits between the target gate and the host-side logging logic.

---
 rtl/xor_fault_monitor.sv | 182 ++++++++++++++++++
 tb/tb_xor_fault_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fault_monitor.sv
`timescale 1ns/1ps
// xor_fault_monitor
//   Stimulus/checker stage for a 6-input XOR target gate. It sweeps the
//   target input through all 64 patterns. Each pattern is held for a settle
//   window, and then the target output is sampled and compared with the
//   expected parity. Every mismatch is reported as a fault record over a
//   valid/ready handshake. Saturating counters track faults and completed
//   sweeps.
//
// Ports
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   en             run enable (checked in IDLE and when leaving a pattern)
//   clr            synchronous clear of fault_count and sweep_count
//   a[5:0]         registered stimulus to the target gate
//   q              target output (asynchronous, synchronised here)
//   fault_valid    fault record available
//   fault_ready    consumer accepts the fault record
//   fault_pattern  value of a at which the fault was sampled
//   fault_q        sampled (wrong) q value
//   fault_count    total faults, saturating
//   sweep_count    completed 64-pattern sweeps, saturating
//   busy           high whenever the monitor is not idle
module xor_fault_monitor #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [5:0]       a,
  input  logic             q,
  output logic             fault_valid,
  input  logic             fault_ready,
  output logic [5:0]       fault_pattern,
  output logic             fault_q,
  output logic [CNT_W-1:0] fault_count,
  output logic [CNT_W-1:0] sweep_count,
  output logic             busy
);

  // The settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             q_meta_reg, q_s_reg;
  logic [SCW-1:0]   settle_reg, settle_next;
  logic [5:0]       a_reg, a_next;
  logic             fault_valid_reg, fault_valid_next;
  logic [5:0]       fault_pattern_reg, fault_pattern_next;
  logic             fault_q_reg, fault_q_next;
  logic [CNT_W-1:0] fault_count_reg, fault_count_next;
  logic [CNT_W-1:0] sweep_count_reg, sweep_count_next;
  logic             busy_reg, busy_next;

  logic advance;    // step a to the next pattern on this edge
  logic fault_inc;  // a mismatch is recorded on this edge
  logic sweep_inc;  // a wraps from 63 to 0 on this edge
  logic match;

  assign match = (q_s_reg == ^a_reg);

  always_comb begin
    state_next         = state_reg;
    settle_next        = settle_reg;
    a_next             = a_reg;
    fault_valid_next   = fault_valid_reg;
    fault_pattern_next = fault_pattern_reg;
    fault_q_next       = fault_q_reg;
    advance            = 1'b0;
    fault_inc          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next  = DRIVE;
          settle_next = '0;
        end
      end
      DRIVE: begin
        // en is deliberately ignored: a started pattern is always sampled.
        if (settle_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      SAMPLE: begin
        if (match) begin
          advance     = 1'b1;
          settle_next = '0;
          state_next  = en ? DRIVE : IDLE;
        end else begin
          fault_valid_next   = 1'b1;
          fault_pattern_next = a_reg;
          fault_q_next       = q_s_reg;
          fault_inc          = 1'b1;
          state_next         = REPORT;
        end
      end
      REPORT: begin
        if (fault_valid_reg && fault_ready) begin
          advance          = 1'b1;
          fault_valid_next = 1'b0;
          settle_next      = '0;
          state_next       = en ? DRIVE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    sweep_inc = advance && (a_reg == 6'd63);
    if (advance) begin
      a_next = a_reg + 6'd1;
    end

    // clr takes priority over a same-cycle increment.
    fault_count_next = fault_count_reg;
    if (clr) begin
      fault_count_next = '0;
    end else if (fault_inc && (fault_count_reg != CNT_MAX)) begin
      fault_count_next = fault_count_reg + 1'b1;
    end

    sweep_count_next = sweep_count_reg;
    if (clr) begin
      sweep_count_next = '0;
    end else if (sweep_inc && (sweep_count_reg != CNT_MAX)) begin
      sweep_count_next = sweep_count_reg + 1'b1;
    end

    // Registered from the next state so busy tracks the state register.
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      q_meta_reg        <= 1'b0;
      q_s_reg           <= 1'b0;
      settle_reg        <= '0;
      a_reg             <= 6'd0;
      fault_valid_reg   <= 1'b0;
      fault_pattern_reg <= 6'd0;
      fault_q_reg       <= 1'b0;
      fault_count_reg   <= '0;
      sweep_count_reg   <= '0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      q_meta_reg        <= q;
      q_s_reg           <= q_meta_reg;
      settle_reg        <= settle_next;
      a_reg             <= a_next;
      fault_valid_reg   <= fault_valid_next;
      fault_pattern_reg <= fault_pattern_next;
      fault_q_reg       <= fault_q_next;
      fault_count_reg   <= fault_count_next;
      sweep_count_reg   <= sweep_count_next;
      busy_reg          <= busy_next;
    end
  end

  assign a             = a_reg;
  assign fault_valid   = fault_valid_reg;
  assign fault_pattern = fault_pattern_reg;
  assign fault_q       = fault_q_reg;
  assign fault_count   = fault_count_reg;
  assign sweep_count   = sweep_count_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_xor_fault_monitor.sv
`timescale 1ns/1ps
module tb_xor_fault_monitor;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, fault_ready;
  logic        q;
  logic [5:0]  a;
  logic        fault_valid, fault_q, busy;
  logic [5:0]  fault_pattern;
  logic [15:0] fault_count, sweep_count;

  // Target gate plant: golden parity, optionally stuck at 0 or inverted at one pattern.
  logic       stuck0, inv_en;
  logic [5:0] inv_pat;
  assign q = stuck0 ? 1'b0 : ((^a) ^ (inv_en && (a == inv_pat)));

  // Second instance with narrow counters for saturation; its gate is stuck at 0.
  logic       en2, clr2, q2, ready2;
  logic [5:0] a2, fault_pattern2;
  logic       fault_valid2, fault_q2, busy2;
  logic [3:0] fault_count2, sweep_count2;

  always #5 clk = ~clk;

  xor_fault_monitor #(.SETTLE_CYCLES(S), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .q(q),
    .fault_valid(fault_valid), .fault_ready(fault_ready),
    .fault_pattern(fault_pattern), .fault_q(fault_q),
    .fault_count(fault_count), .sweep_count(sweep_count), .busy(busy)
  );

  xor_fault_monitor #(.SETTLE_CYCLES(S), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .a(a2), .q(q2),
    .fault_valid(fault_valid2), .fault_ready(ready2),
    .fault_pattern(fault_pattern2), .fault_q(fault_q2),
    .fault_count(fault_count2), .sweep_count(sweep_count2), .busy(busy2)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pattern is "running" for S settle cycles followed by one sample cycle;
  // m_t counts cycles spent on the current pattern. The model sees q through
  // a two-deep delay line, like the gate output seen after synchronisation.
  logic        m_run, m_rep;
  int          m_t;
  logic [5:0]  m_a, m_fp;
  logic        m_fq;
  logic        m_qh0, m_qh1;
  int          m_fc, m_sc;

  wire m_sample = m_run && (m_t == S);
  wire m_match  = (m_qh1 == ^m_a);
  wire m_fault  = m_sample && !m_match;
  wire m_adv    = (m_sample && m_match) || (m_rep && fault_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_rep <= 1'b0; m_t <= 0; m_a <= '0; m_fp <= '0; m_fq <= 1'b0;
      m_qh0 <= 1'b0; m_qh1 <= 1'b0; m_fc <= 0; m_sc <= 0;
    end else begin
      m_qh0 <= q;
      m_qh1 <= m_qh0;
      if (m_adv) begin
        m_a   <= m_a + 6'd1;
        m_rep <= 1'b0;
        m_run <= en;
        m_t   <= 0;
      end else if (m_fault) begin
        m_fp  <= m_a;
        m_fq  <= m_qh1;
        m_run <= 1'b0;
        m_rep <= 1'b1;
      end else if (!m_run && !m_rep) begin
        if (en) begin
          m_run <= 1'b1;
          m_t   <= 0;
        end
      end else if (m_run) begin
        m_t <= m_t + 1;
      end
      if (clr) m_fc <= 0;
      else if (m_fault && m_fc != 65535) m_fc <= m_fc + 1;
      if (clr) m_sc <= 0;
      else if (m_adv && m_a == 6'd63 && m_sc != 65535) m_sc <= m_sc + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cyc_a",           32'(a),             32'(m_a));
      chk("cyc_fault_valid", 32'(fault_valid),   32'(m_rep));
      chk("cyc_busy",        32'(busy),          32'(m_run | m_rep));
      chk("cyc_fault_count", 32'(fault_count),   32'(m_fc));
      chk("cyc_sweep_count", 32'(sweep_count),   32'(m_sc));
      chk("cyc_fault_pat",   32'(fault_pattern), 32'(m_fp));
      chk("cyc_fault_q",     32'(fault_q),       32'(m_fq));
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; fault_ready = 1'b0;
    stuck0 = 1'b0; inv_en = 1'b0; en2 = 1'b0; clr2 = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_fv(input int budget, input string nm);
    int k = 0;
    while (fault_valid !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    chk(nm, 32'(fault_valid), 32'd1);
  endtask

  task automatic wait_a(input logic [5:0] v, input int budget, input string nm);
    int k = 0;
    while (a !== v && k < budget) begin @(negedge clk); k++; end
    chk(nm, 32'(a), 32'(v));
  endtask

  task automatic wait_sweep(input int v, input int budget, input string nm);
    int k = 0;
    while (sweep_count !== 16'(v) && k < budget) begin @(negedge clk); k++; end
    chk(nm, 32'(sweep_count), 32'(v));
  endtask

  task automatic wait_sweep2(input int v, input int budget, input string nm);
    int k = 0;
    while (sweep_count2 !== 4'(v) && k < budget) begin @(negedge clk); k++; end
    chk(nm, 32'(sweep_count2), 32'(v));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic any_fv;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; fault_ready = 1'b0;
    stuck0 = 1'b0; inv_en = 1'b0; inv_pat = 6'h2A;
    en2 = 1'b0; clr2 = 1'b0; q2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a",           32'(a),             32'd0);
    chk("rst_fault_valid", 32'(fault_valid),   32'd0);
    chk("rst_busy",        32'(busy),          32'd0);
    chk("rst_fault_count", 32'(fault_count),   32'd0);
    chk("rst_sweep_count", 32'(sweep_count),   32'd0);
    chk("rst_fault_pat",   32'(fault_pattern), 32'd0);
    chk("rst_fault_q",     32'(fault_q),       32'd0);
    #2 rst_n = 1'b1;

    // 1: golden gate, one full sweep without faults.
    $display("test golden_sweep");
    en = 1'b1;
    any_fv = 1'b0;
    for (int i = 0; i < 330; i++) begin
      @(negedge clk);
      if (fault_valid) any_fv = 1'b1;
    end
    chk("golden_no_fault_valid", 32'(any_fv),      32'd0);
    chk("golden_sweep_count",    32'(sweep_count), 32'd1);
    chk("golden_fault_count",    32'(fault_count), 32'd0);

    // 2: q stuck at 0, consumer always ready.
    $display("test stuck0_sweep");
    do_reset();
    stuck0 = 1'b1; fault_ready = 1'b1; en = 1'b1;
    wait_fv(50, "stuck0_first_valid");
    chk("stuck0_first_pattern", 32'(fault_pattern), 32'h01);
    chk("stuck0_first_q",       32'(fault_q),       32'd0);
    wait_sweep(1, 800, "stuck0_sweep_done");
    chk("stuck0_fault_count", 32'(fault_count), 32'd32);

    // 3: single inverted sample at 0x2A, consumer stalls 10 cycles.
    $display("test stalled_report");
    do_reset();
    inv_en = 1'b1; inv_pat = 6'h2A; fault_ready = 1'b0; en = 1'b1;
    wait_fv(400, "stall_valid");
    chk("stall_pattern", 32'(fault_pattern), 32'h2A);
    chk("stall_q",       32'(fault_q),       32'd0);
    chk("stall_a",       32'(a),             32'h2A);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", 32'(fault_valid), 32'd1);
      chk("stall_hold_a",     32'(a),           32'h2A);
    end
    fault_ready = 1'b1;
    @(negedge clk);
    fault_ready = 1'b0;
    chk("stall_after_a",     32'(a),           32'h2B);
    chk("stall_after_valid", 32'(fault_valid), 32'd0);
    inv_en = 1'b0;

    // 4: clr on the same edge as a fault increment.
    $display("test clr_vs_fault");
    do_reset();
    stuck0 = 1'b1; fault_ready = 1'b1; en = 1'b1;
    wait_fv(50, "clr_first_valid");
    repeat (5) @(negedge clk);   // now in the sample cycle of pattern 2
    chk("clr_pre_count", 32'(fault_count), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count",   32'(fault_count),   32'd0);
    chk("clr_valid",   32'(fault_valid),   32'd1);
    chk("clr_pattern", 32'(fault_pattern), 32'h02);

    // 5: narrow counters saturate over two stuck-at-0 sweeps.
    $display("test saturation");
    do_reset();
    en2 = 1'b1;
    wait_sweep2(1, 900, "sat_sweep1");
    chk("sat_count_sweep1", 32'(fault_count2), 32'd15);
    wait_sweep2(2, 900, "sat_sweep2");
    chk("sat_count_sweep2", 32'(fault_count2), 32'd15);
    en2 = 1'b0;

    // 6: drop en mid-pattern at a=5.
    $display("test en_drop");
    do_reset();
    en = 1'b1;
    wait_a(6'h05, 60, "endrop_reach5");
    en = 1'b0;
    wait_a(6'h06, 20, "endrop_reach6");
    chk("endrop_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("endrop_hold_a",    32'(a),    32'h06);
    chk("endrop_hold_busy", 32'(busy), 32'd0);
    en = 1'b1;
    wait_a(6'h07, 20, "endrop_resume");

    // 7: asynchronous reset while a record is pending.
    $display("test reset_in_report");
    do_reset();
    stuck0 = 1'b1; fault_ready = 1'b0; en = 1'b1;
    wait_fv(50, "rstrep_valid");
    chk("rstrep_pre_a",     32'(a),           32'h01);
    chk("rstrep_pre_count", 32'(fault_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrep_valid0", 32'(fault_valid), 32'd0);
    chk("rstrep_a0",     32'(a),           32'd0);
    chk("rstrep_fc0",    32'(fault_count), 32'd0);
    chk("rstrep_sc0",    32'(sweep_count), 32'd0);
    chk("rstrep_busy0",  32'(busy),        32'd0);
    @(negedge clk); #2;
    stuck0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrep_restart_a", 32'(a), 32'd0);
    wait_a(6'h01, 20, "rstrep_restart_step");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
